chdr_pkt_parser: RTL
====================

# chdr_pkt_parser

Parametrised CHDR packet parser for the RFNoC CHDR bus. It accepts one AXI-Stream of CHDR packets at any supported CHDR width and decodes the header and timestamp into registered sideband fields. It strips the header, timestamp and (optionally) metadata, and forwards the payload downstream. It also checks each packet's length field against the actual beat count, checks sequence-number continuity, and reports per-packet status and counters. It sits between a transport adapter and a stream endpoint.

## Interface
- CHDR_W, 64, CHDR bus width in bits; legal values are 64, 128, 256, 512.
- DROP_MDATA, 1, 1 drops metadata beats; 0 forwards them on m_axis with m_axis_tuser = 1.

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous, active-low reset.
- s_axis_tdata / tlast / tvalid / tready  in/in/in/out  CHDR_W/1/1/1  input CHDR packets.
- m_axis_tdata / tlast / tuser / tvalid / tready  out/out/out/out/in  CHDR_W/1/1/1/1  payload out; tuser = 1 marks a metadata beat.
- hdr_valid  out  1  one-cycle pulse when a header has been decoded.
- hdr_flags, hdr_pkt_type, hdr_num_mdata, hdr_seq_num, hdr_length, hdr_dst_epid  out  6/3/7/16/16/16  registered header fields.
- hdr_has_time  out  1  1 when pkt_type = 7.
- hdr_timestamp  out  64  registered timestamp.
- seq_clear  in  1  pulse that clears sequence tracking.
- stat_valid  out  1  one-cycle pulse per completed packet.
- stat_len_err, stat_seq_err  out  1/1  status qualifiers, valid while stat_valid = 1.
- pkt_count  out  32  packets completed, wraps.
- err_count  out  16  packets with any error; saturates at 0xFFFF.

## Operation
- Header word layout (bits 63:0 of the first beat), MSB to LSB: flags[6], pkt_type[3], num_mdata[7], seq_num[16], length[16], dst_epid[16].

State machine: HDR, TS, MDATA, PAYLOAD. Reset state is HDR.
- HDR: s_axis_tready = 1. On an accepted beat:
  - Capture the header fields.
  - If CHDR_W ≥ 128 and pkt_type = 7, capture the timestamp from bits 127:64 of the same beat.
  - Next state:
    - TS if CHDR_W = 64 and pkt_type = 7;
    - else MDATA if num_mdata > 0;
    - else PAYLOAD.
  - If tlast is set on the header beat, the packet ends and the state stays HDR.
- TS (CHDR_W = 64 only): s_axis_tready = 1. Capture the full word as the timestamp, then go to MDATA or PAYLOAD using the same num_mdata rule.
- MDATA: consumes num_mdata beats using a 7-bit down-counter, then goes to PAYLOAD.
  - DROP_MDATA = 1: s_axis_tready = 1 and nothing is forwarded.
  - DROP_MDATA = 0: beats pass through with backpressure, like PAYLOAD, with tuser = 1.
- PAYLOAD: pass-through.
  - m_axis_tdata = s_axis_tdata and m_axis_tlast = s_axis_tlast.
  - m_axis_tvalid = s_axis_tvalid and s_axis_tready = m_axis_tready.
- End of packet: an accepted beat with tlast set, in any state, returns the FSM to HDR. An early tlast in TS or MDATA is legal and ends the packet.

Length check:
- expected_beats = (length + CHDR_W/8 − 1) >> log2(CHDR_W/8), computed in 17 bits.
- A 16-bit beat counter counts every accepted input beat and saturates.
- stat_len_err = 1 when the count at tlast ≠ expected_beats.
- Packets are never truncated or padded.

Sequence check:
- The first packet after reset or seq_clear is not checked; it only loads the tracker.
- After that, stat_seq_err = 1 when seq_num ≠ (previous seq_num + 1) mod 2^16.
- The tracker always loads the received seq_num, so a single gap flags exactly one packet.
- seq_clear asserted in the same cycle as a header beat takes priority: that packet is not checked.

Counters:
- pkt_count increments on every stat_valid.
- err_count increments when stat_len_err or stat_seq_err is set.

## Timing
- Reset values: all outputs 0; m_axis_tvalid = 0 and s_axis_tready = 0 while rst_n is low; state HDR.
- Payload path is combinational: zero latency, no extra buffering, and full throughput with 1 beat per cycle.
- hdr_valid pulses the cycle after the header beat is accepted.
- The header fields update on that same edge and hold until the next header beat. This means they are stable for every payload beat of the packet.
- The timestamp updates on the TS accept edge (CHDR_W = 64) or the header accept edge (CHDR_W ≥ 128).
- stat_valid, the error flags and the counters are registered and appear the cycle after the tlast beat is accepted.
- Back-to-back packets with no idle cycles between them are supported.
- Reset asserted mid-packet returns the FSM to HDR. The remainder of the interrupted packet is then parsed as a new packet, and upstream is responsible for flushing it.

## Test plan
- CHDR_W=64, pkt_type=7, num_mdata=1, length=40, 5 beats with payload 0xA, 0xB → hdr_timestamp = word 1, metadata dropped, m_axis carries 0xA then 0xB with tlast on 0xB, stat_len_err=0.
- CHDR_W=256, pkt_type=7, length=72, 3 beats, timestamp in bits 127:64 → no TS state, 2 payload beats out, hdr_has_time=1.
- Header-only packet, length=8, tlast on the header beat (CHDR_W=64) → no m_axis beat, stat_valid=1, both error flags 0.
- Sequence 5, 6, 8, 9 → stat_seq_err on the third packet only, err_count=1, pkt_count=4; seq_clear followed by seq 0 → no error.
- length=48 but tlast on beat 4 (CHDR_W=64) → stat_len_err=1. Random m_axis_tready with 30% stalls → no beat lost or duplicated.
- DROP_MDATA=0, num_mdata=2 → 2 beats out with tuser=1, then payload beats with tuser=0. Reset asserted mid-payload → all outputs 0 on the next cycle.

Source files
------------

// File: rtl/chdr_pkt_parser.sv
// CHDR packet parser: decodes header/timestamp into registered sideband fields,
// strips header/timestamp/metadata and checks length and sequence continuity.
module chdr_pkt_parser #(
  parameter int unsigned CHDR_W     = 64,
  parameter bit          DROP_MDATA = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CHDR_W-1:0] s_axis_tdata,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [CHDR_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  output logic              m_axis_tuser,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              hdr_valid,
  output logic [5:0]        hdr_flags,
  output logic [2:0]        hdr_pkt_type,
  output logic [6:0]        hdr_num_mdata,
  output logic [15:0]       hdr_seq_num,
  output logic [15:0]       hdr_length,
  output logic [15:0]       hdr_dst_epid,
  output logic              hdr_has_time,
  output logic [63:0]       hdr_timestamp,
  input  logic              seq_clear,
  output logic              stat_valid,
  output logic              stat_len_err,
  output logic              stat_seq_err,
  output logic [31:0]       pkt_count,
  output logic [15:0]       err_count
);

  localparam int unsigned BYTES  = CHDR_W / 8;
  localparam int unsigned LOG2_B = $clog2(BYTES);

  typedef enum logic [1:0] {ST_HDR, ST_TS, ST_MDATA, ST_PAYLOAD} state_t;

  state_t      state, state_nxt;
  logic        s_acc, fwd, hdr_acc, last_acc;
  logic [6:0]  mcnt;
  logic [15:0] beat_cnt, beat_nxt;
  logic        seq_loaded, pkt_seq_err;
  logic [15:0] seq_prev;
  logic [63:0] ts_hdr;

  logic [2:0]  in_type;
  logic [6:0]  in_nm;
  logic [15:0] in_seq, in_len, cur_len;
  logic [16:0] exp_beats;
  logic        seq_chk, len_err_c, seq_err_c;

  assign in_type = s_axis_tdata[57:55];
  assign in_nm   = s_axis_tdata[54:48];
  assign in_seq  = s_axis_tdata[47:32];
  assign in_len  = s_axis_tdata[31:16];

  // Wide buses carry the timestamp alongside the header word
  if (CHDR_W >= 128) begin : g_ts_wide
    assign ts_hdr = s_axis_tdata[127:64];
  end else begin : g_ts_narrow
    assign ts_hdr = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_HDR;
    else        state <= state_nxt;
  end

  // Next state and the combinational payload path
  always_comb begin
    state_nxt     = state;
    fwd           = 1'b0;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    unique case (state)
      ST_HDR, ST_TS: s_axis_tready = rst_n;
      ST_MDATA: begin
        if (DROP_MDATA) s_axis_tready = rst_n;
        else            fwd = rst_n;
      end
      ST_PAYLOAD: fwd = rst_n;
      default: ;
    endcase
    if (fwd) begin
      s_axis_tready = m_axis_tready;
      m_axis_tvalid = s_axis_tvalid;
      m_axis_tdata  = s_axis_tdata;
      m_axis_tlast  = s_axis_tlast;
      m_axis_tuser  = (state == ST_MDATA);
    end
    s_acc = s_axis_tvalid & s_axis_tready;
    if (s_acc) begin
      unique case (state)
        ST_HDR: begin
          if (CHDR_W == 64 && in_type == 3'd7) state_nxt = ST_TS;
          else if (in_nm != 7'd0)              state_nxt = ST_MDATA;
          else                                 state_nxt = ST_PAYLOAD;
        end
        ST_TS:    state_nxt = (mcnt != 7'd0) ? ST_MDATA : ST_PAYLOAD;
        ST_MDATA: if (mcnt <= 7'd1) state_nxt = ST_PAYLOAD;
        default: ;
      endcase
      if (s_axis_tlast) state_nxt = ST_HDR;
    end
  end

  assign hdr_acc  = s_acc && (state == ST_HDR);
  assign last_acc = s_acc && s_axis_tlast;

  // Header-only packets are judged from the live beat, others from the held header
  assign beat_nxt  = (beat_cnt == 16'hFFFF) ? beat_cnt : beat_cnt + 16'd1;
  assign cur_len   = (state == ST_HDR) ? in_len : hdr_length;
  assign exp_beats = (17'(cur_len) + 17'(BYTES - 1)) >> LOG2_B;
  assign len_err_c = ({1'b0, beat_nxt} != exp_beats);
  assign seq_chk   = seq_loaded && !seq_clear && (in_seq != seq_prev + 16'd1);
  assign seq_err_c = (state == ST_HDR) ? seq_chk : pkt_seq_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_valid     <= 1'b0;
      hdr_flags     <= '0;
      hdr_pkt_type  <= '0;
      hdr_num_mdata <= '0;
      hdr_seq_num   <= '0;
      hdr_length    <= '0;
      hdr_dst_epid  <= '0;
      hdr_has_time  <= 1'b0;
      hdr_timestamp <= '0;
      mcnt          <= '0;
      beat_cnt      <= '0;
      seq_loaded    <= 1'b0;
      seq_prev      <= '0;
      pkt_seq_err   <= 1'b0;
      stat_valid    <= 1'b0;
      stat_len_err  <= 1'b0;
      stat_seq_err  <= 1'b0;
      pkt_count     <= '0;
      err_count     <= '0;
    end else begin
      hdr_valid  <= hdr_acc;
      stat_valid <= last_acc;
      if (hdr_acc) begin
        hdr_flags     <= s_axis_tdata[63:58];
        hdr_pkt_type  <= in_type;
        hdr_num_mdata <= in_nm;
        hdr_seq_num   <= in_seq;
        hdr_length    <= in_len;
        hdr_dst_epid  <= s_axis_tdata[15:0];
        hdr_has_time  <= (in_type == 3'd7);
        mcnt          <= in_nm;
        pkt_seq_err   <= seq_chk;
        seq_prev      <= in_seq;
        seq_loaded    <= 1'b1;
        if (CHDR_W >= 128 && in_type == 3'd7) hdr_timestamp <= ts_hdr;
      end else if (seq_clear) begin
        seq_loaded <= 1'b0;
      end
      if (s_acc && state == ST_TS)    hdr_timestamp <= s_axis_tdata[63:0];
      if (s_acc && state == ST_MDATA) mcnt <= mcnt - 7'd1;
      if (last_acc)   beat_cnt <= '0;
      else if (s_acc) beat_cnt <= beat_nxt;
      if (last_acc) begin
        stat_len_err <= len_err_c;
        stat_seq_err <= seq_err_c;
        pkt_count    <= pkt_count + 32'd1;
        if ((len_err_c || seq_err_c) && err_count != 16'hFFFF)
          err_count <= err_count + 16'd1;
      end
    end
  end

endmodule
